ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
// - Consumer of the ID-stage 8-bit control word: carries EX/M/WB fields through ID/EX, EX/MEM, MEM/WB.
// - Tracks destination registers per stage; detects load-use hazards; issues stall and IF/ID flush.
// - Sits beside the ID-stage decoder; its outputs drive the EX muxes, data memory enables and write-back.
// PARAMETERS
// - REG_AW   5   register-address width
// - CNT_W    32  performance-counter width (PERF_CNT_EN only)
// PORTS
// - clk_i          in   1   clock
// - rst_i          in   1   reset, synchronous, active-high
// - ctrl_i         in   8   ID control word: [0]ALUSrc [2:1]ALUOp [3]RegDst [4]MemRead [5]MemWrite [6]RegWrite [7]MemtoReg(1=ALU,0=mem)
// - rs_id_i        in   5   rs of instruction in ID
// - rt_id_i        in   5   rt of instruction in ID
// - rd_id_i        in   5   rd of instruction in ID
// - jump_i         in   1   jump decoded in ID
// - branch_taken_i in   1   branch resolved taken in ID
// - ex_alusrc_o    out  1   ID/EX ALUSrc
// - ex_aluop_o     out  2   ID/EX ALUOp
// - ex_wreg_o      out  5   EX destination (rd if RegDst else rt)
// - mem_read_o     out  1   EX/MEM MemRead
// - mem_write_o    out  1   EX/MEM MemWrite
// - wb_regwrite_o  out  1   MEM/WB RegWrite
// - wb_memtoreg_o  out  1   MEM/WB MemtoReg
// - wb_wreg_o      out  5   MEM/WB destination register
// - stall_o        out  1   hold PC and IF/ID (combinational)
// - ifid_flush_o   out  1   clear IF/ID (combinational)
// BEHAVIOUR
// - Reset: all three stage registers load BUBBLE = 8'h0E (ALUOp=11, RegDst=1, all enables 0); all wreg fields 0.
// - Reset mid-operation: every in-flight control word discarded next edge; no write/mem enable asserts the cycle after rst_i.
// - Latency: ctrl_i -> EX outputs 1 cycle, -> MEM outputs 2, -> WB outputs 3.
// - Load-use: stall_o = idex.MemRead & idex.rt!=0 & (idex.rt==rs_id_i | idex.rt==rt_id_i).
// - On stall: ID/EX loads BUBBLE; EX/MEM, MEM/WB advance normally; ctrl_i re-presented next cycle.
// - Flush: ifid_flush_o = (jump_i | branch_taken_i) & ~stall_o; stall wins, branch re-evaluated next cycle.
// - Flush does not bubble ID/EX; the jump/branch itself advances with its own (disabled) control word.
// - EX/MEM wreg = RegDst ? rd : rt, resolved in EX; passed unchanged to MEM/WB.
// - wb_regwrite_o forced 0 when wb_wreg_o==0 ($zero never written).
// - Back-to-back loads: each checked independently; at most one bubble per load-use pair.
// - No state machine beyond the 3-stage shift; no X from unknown ctrl_i bits—pass through as received.
// CONFIGURATION
// - PERF_CNT_EN defined: adds stall_cnt_o[CNT_W] (stall cycles) and flush_cnt_o[CNT_W] (flush cycles);
//   cleared on rst_i, saturate at all-ones.
// - PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
// - ctrl_pipe_pkg: bit-position constants (ALUSRC_B, ALUOP_LSB, REGDST_B, MEMRD_B, MEMWR_B, REGWR_B, MEMTOREG_B),
//   BUBBLE = 8'h0E, stage-record typedef {ctrl, rt, rd, wreg}.
// - Sub-module ctrl_pipe_stage: one register stage with load-bubble and reset; instanced three times.
// TESTING
// - Reset: assert rst_i 2 cycles with ctrl_i=8'hFF -> all enables 0, ex_aluop_o=2'b11, wregs 0.
// - Pass-through: R-type 8'hCE rd=5 -> ex_wreg_o=5 at +1, wb_regwrite_o=1 wb_wreg_o=5 at +3.
// - Load-use: lw 8'h53 rt=8, then add rs=8 -> stall_o=1 one cycle, one bubble in EX, add re-issued.
// - Load, non-dependent: lw rt=8, next uses rs=3 rt=4 -> stall_o=0, no bubble.
// - Jump during stall: load-use stall with jump_i=1 -> ifid_flush_o=0; next cycle ifid_flush_o=1.
// - $zero dest: addi 8'hC1 rt=0 -> wb_regwrite_o=0 at +3; (PERF_CNT_EN) stall_cnt_o increments per stall.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control pipeline: field positions inside the
// ID control word, the bubble encoding and the per-stage record.
// Optional feature macro used by this slice: PERF_CNT_EN.
package ctrl_pipe_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  // Bit positions inside the 8-bit ID control word
  localparam int unsigned ALUSRC_B   = 0;
  localparam int unsigned ALUOP_LSB  = 1;
  localparam int unsigned REGDST_B   = 3;
  localparam int unsigned MEMRD_B    = 4;
  localparam int unsigned MEMWR_B    = 5;
  localparam int unsigned REGWR_B    = 6;
  localparam int unsigned MEMTOREG_B = 7;

  // ALUOp=11, RegDst=1, every enable low
  localparam logic [7:0] BUBBLE = 8'h0E;

  typedef struct packed {
    logic [7:0]            ctrl;
    logic [REG_AW_DEF-1:0] rt;
    logic [REG_AW_DEF-1:0] rd;
    logic [REG_AW_DEF-1:0] wreg;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{ctrl: BUBBLE, rt: '0, rd: '0, wreg: '0};

endpackage

// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bus: ID-stage inputs toward the pipeline and the
// EX/MEM/WB control outputs back to the datapath.
// slave = the pipeline itself, master = the decoder/datapath side.
interface ctrl_pipe_if
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
);
  logic [7:0]        ctrl_i;
  logic [REG_AW-1:0] rs_id_i;
  logic [REG_AW-1:0] rt_id_i;
  logic [REG_AW-1:0] rd_id_i;
  logic              jump_i;
  logic              branch_taken_i;

  logic              ex_alusrc_o;
  logic [1:0]        ex_aluop_o;
  logic [REG_AW-1:0] ex_wreg_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic              wb_regwrite_o;
  logic              wb_memtoreg_o;
  logic [REG_AW-1:0] wb_wreg_o;
  logic              stall_o;
  logic              ifid_flush_o;

  modport master (
    output ctrl_i, rs_id_i, rt_id_i, rd_id_i, jump_i, branch_taken_i,
    input  ex_alusrc_o, ex_aluop_o, ex_wreg_o, mem_read_o, mem_write_o,
           wb_regwrite_o, wb_memtoreg_o, wb_wreg_o, stall_o, ifid_flush_o
  );

  modport slave (
    input  ctrl_i, rs_id_i, rt_id_i, rd_id_i, jump_i, branch_taken_i,
    output ex_alusrc_o, ex_aluop_o, ex_wreg_o, mem_read_o, mem_write_o,
           wb_regwrite_o, wb_memtoreg_o, wb_wreg_o, stall_o, ifid_flush_o
  );

endinterface

// File: rtl/ctrl_pipe_stage.sv
// One pipeline register holding a stage record; reset and bubble both load
// the disabled control word with zeroed register fields.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   bubble_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_q;

  // Synchronous reset / bubble insert, otherwise advance
  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_i) begin
      stage_q <= STAGE_BUBBLE;
    end else begin
      stage_q <= d_i;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the ID control word through ID/EX, EX/MEM and MEM/WB, tracks the
// destination register per stage, and raises load-use stall / IF/ID flush.
// Optional: define PERF_CNT_EN to add saturating stall/flush cycle counters.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
`ifdef PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ctrl_pipe_if.slave       bus
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  stage_t            idex_d, idex_q;
  stage_t            exmem_d, exmem_q;
  stage_t            memwb_q;
  logic [REG_AW-1:0] ex_wreg;
  logic              stall;
  logic              flush;

  // Load-use hazard against the instruction sitting in EX
  always_comb begin
    stall = idex_q.ctrl[MEMRD_B] && (idex_q.rt != '0) &&
            ((idex_q.rt == bus.rs_id_i) || (idex_q.rt == bus.rt_id_i));
    // Stall wins; a pending jump/branch is re-evaluated once the bubble is in
    flush = (bus.jump_i || bus.branch_taken_i) && !stall;
  end

  // Stage inputs: ID fields into ID/EX, destination resolved in EX
  always_comb begin
    idex_d      = '0;
    idex_d.ctrl = bus.ctrl_i;
    idex_d.rt   = bus.rt_id_i;
    idex_d.rd   = bus.rd_id_i;
    ex_wreg     = idex_q.ctrl[REGDST_B] ? idex_q.rd : idex_q.rt;
    exmem_d     = idex_q;
    exmem_d.wreg = ex_wreg;
  end

  ctrl_pipe_stage u_idex (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (stall),
    .d_i      (idex_d),
    .q_o      (idex_q)
  );

  ctrl_pipe_stage u_exmem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (1'b0),
    .d_i      (exmem_d),
    .q_o      (exmem_q)
  );

  ctrl_pipe_stage u_memwb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (1'b0),
    .d_i      (exmem_q),
    .q_o      (memwb_q)
  );

  // Per-stage control outputs; $zero is never written back
  always_comb begin
    bus.ex_alusrc_o   = idex_q.ctrl[ALUSRC_B];
    bus.ex_aluop_o    = idex_q.ctrl[ALUOP_LSB +: 2];
    bus.ex_wreg_o     = ex_wreg;
    bus.mem_read_o    = exmem_q.ctrl[MEMRD_B];
    bus.mem_write_o   = exmem_q.ctrl[MEMWR_B];
    bus.wb_regwrite_o = memwb_q.ctrl[REGWR_B] && (memwb_q.wreg != '0);
    bus.wb_memtoreg_o = memwb_q.ctrl[MEMTOREG_B];
    bus.wb_wreg_o     = memwb_q.wreg;
    bus.stall_o       = stall;
    bus.ifid_flush_o  = flush;
  end

  // Fields that only matter in earlier stages
  logic unused_wb_fields;
  assign unused_wb_fields = ^{memwb_q.ctrl[REGWR_B-1:0], memwb_q.rt, memwb_q.rd};

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating stall/flush cycle counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe.
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  ctrl_pipe_if #(.REG_AW(5)) bus ();

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  ctrl_pipe #(.REG_AW(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic [7:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic j, input logic br);
    bus.ctrl_i         = c;
    bus.rs_id_i        = rs;
    bus.rt_id_i        = rt;
    bus.rd_id_i        = rd;
    bus.jump_i         = j;
    bus.branch_taken_i = br;
  endtask

  task automatic idle();
    set_in(8'h0E, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(8'hFF, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0);
    step();
    step();
    n_total++; if (bus.ex_aluop_o !== 2'b11) $display("FAIL rst_aluop got %0h want 3", bus.ex_aluop_o); else n_pass++;
    n_total++; if (bus.ex_alusrc_o !== 1'b0) $display("FAIL rst_alusrc got %0b want 0", bus.ex_alusrc_o); else n_pass++;
    n_total++; if (bus.ex_wreg_o !== 5'd0) $display("FAIL rst_ex_wreg got %0d want 0", bus.ex_wreg_o); else n_pass++;
    n_total++; if ({bus.mem_read_o, bus.mem_write_o} !== 2'b00) $display("FAIL rst_mem_en got %b want 00", {bus.mem_read_o, bus.mem_write_o}); else n_pass++;
    n_total++; if (bus.wb_regwrite_o !== 1'b0) $display("FAIL rst_wb_regwrite got %0b want 0", bus.wb_regwrite_o); else n_pass++;
    n_total++; if (bus.wb_wreg_o !== 5'd0) $display("FAIL rst_wb_wreg got %0d want 0", bus.wb_wreg_o); else n_pass++;
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL rst_stall got %0b want 0", bus.stall_o); else n_pass++;
    // Fill the pipe with all-enable words, then reset mid-flight
    rst = 1'b0;
    set_in(8'hFF, 5'd1, 5'd0, 5'd3, 1'b0, 1'b0);
    step();
    step();
    step();
    n_total++; if (bus.wb_regwrite_o !== 1'b1) $display("FAIL full_wb_regwrite got %0b want 1", bus.wb_regwrite_o); else n_pass++;
    n_total++; if (bus.wb_wreg_o !== 5'd3) $display("FAIL full_wb_wreg got %0d want 3", bus.wb_wreg_o); else n_pass++;
    n_total++; if ({bus.mem_read_o, bus.mem_write_o} !== 2'b11) $display("FAIL full_mem_en got %b want 11", {bus.mem_read_o, bus.mem_write_o}); else n_pass++;
    rst = 1'b1;
    step();
    n_total++; if ({bus.mem_read_o, bus.mem_write_o, bus.wb_regwrite_o, bus.ex_alusrc_o} !== 4'b0000)
      $display("FAIL midrst_enables got %b want 0000", {bus.mem_read_o, bus.mem_write_o, bus.wb_regwrite_o, bus.ex_alusrc_o});
    else n_pass++;
    rst = 1'b0;
    idle();
  endtask

  task automatic test_pass_through();
    do_reset();
    set_in(8'hCE, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);   // R-type, rd=5
    step();
    n_total++; if (bus.ex_wreg_o !== 5'd5) $display("FAIL pt_ex_wreg got %0d want 5", bus.ex_wreg_o); else n_pass++;
    n_total++; if (bus.ex_aluop_o !== 2'b11) $display("FAIL pt_ex_aluop got %0h want 3", bus.ex_aluop_o); else n_pass++;
    set_in(8'h21, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0);   // sw, rt=6
    step();
    n_total++; if (bus.ex_alusrc_o !== 1'b1) $display("FAIL pt_sw_alusrc got %0b want 1", bus.ex_alusrc_o); else n_pass++;
    n_total++; if (bus.ex_wreg_o !== 5'd6) $display("FAIL pt_sw_ex_wreg got %0d want 6", bus.ex_wreg_o); else n_pass++;
    n_total++; if (bus.mem_write_o !== 1'b0) $display("FAIL pt_rtype_memwr got %0b want 0", bus.mem_write_o); else n_pass++;
    idle();
    step();
    n_total++; if (bus.mem_write_o !== 1'b1) $display("FAIL pt_sw_memwr got %0b want 1", bus.mem_write_o); else n_pass++;
    n_total++; if (bus.wb_regwrite_o !== 1'b1) $display("FAIL pt_wb_regwrite got %0b want 1", bus.wb_regwrite_o); else n_pass++;
    n_total++; if (bus.wb_wreg_o !== 5'd5) $display("FAIL pt_wb_wreg got %0d want 5", bus.wb_wreg_o); else n_pass++;
    n_total++; if (bus.wb_memtoreg_o !== 1'b1) $display("FAIL pt_wb_memtoreg got %0b want 1", bus.wb_memtoreg_o); else n_pass++;
    step();
    n_total++; if (bus.wb_regwrite_o !== 1'b0) $display("FAIL pt_sw_wb_regwrite got %0b want 0", bus.wb_regwrite_o); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(8'h53, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);   // lw rt=8
    step();
    set_in(8'hCE, 5'd8, 5'd2, 5'd10, 1'b0, 1'b0);  // add rs=8 rd=10
    #1;
    n_total++; if (bus.stall_o !== 1'b1) $display("FAIL lu_stall got %0b want 1", bus.stall_o); else n_pass++;
    step();
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL lu_stall_once got %0b want 0", bus.stall_o); else n_pass++;
    n_total++; if ({bus.ex_aluop_o, bus.ex_alusrc_o, bus.ex_wreg_o} !== {2'b11, 1'b0, 5'd0})
      $display("FAIL lu_bubble got %0h want %0h", {bus.ex_aluop_o, bus.ex_alusrc_o, bus.ex_wreg_o}, {2'b11, 1'b0, 5'd0});
    else n_pass++;
    n_total++; if (bus.mem_read_o !== 1'b1) $display("FAIL lu_mem_read got %0b want 1", bus.mem_read_o); else n_pass++;
    step();
    n_total++; if (bus.ex_wreg_o !== 5'd10) $display("FAIL lu_reissue got %0d want 10", bus.ex_wreg_o); else n_pass++;
    n_total++; if ({bus.wb_regwrite_o, bus.wb_memtoreg_o, bus.wb_wreg_o} !== {1'b1, 1'b0, 5'd8})
      $display("FAIL lu_wb_load got %0h want %0h", {bus.wb_regwrite_o, bus.wb_memtoreg_o, bus.wb_wreg_o}, {1'b1, 1'b0, 5'd8});
    else n_pass++;
    idle();
    step();
    n_total++; if (bus.wb_regwrite_o !== 1'b0) $display("FAIL lu_wb_bubble got %0b want 0", bus.wb_regwrite_o); else n_pass++;
    step();
    n_total++; if (bus.wb_wreg_o !== 5'd10) $display("FAIL lu_wb_add got %0d want 10", bus.wb_wreg_o); else n_pass++;
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_in(8'h53, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    step();
    set_in(8'hCE, 5'd3, 5'd4, 5'd9, 1'b0, 1'b0);
    #1;
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL nh_stall got %0b want 0", bus.stall_o); else n_pass++;
    step();
    n_total++; if (bus.ex_wreg_o !== 5'd9) $display("FAIL nh_no_bubble got %0d want 9", bus.ex_wreg_o); else n_pass++;
    // Load to $zero never stalls its consumer
    set_in(8'h53, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    set_in(8'hCE, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    #1;
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL nh_zero_stall got %0b want 0", bus.stall_o); else n_pass++;
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(8'h53, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);   // lw r8
    step();
    set_in(8'h53, 5'd8, 5'd9, 5'd0, 1'b0, 1'b0);   // lw r9, base r8
    #1;
    n_total++; if (bus.stall_o !== 1'b1) $display("FAIL b2b_stall1 got %0b want 1", bus.stall_o); else n_pass++;
    step();
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL b2b_stall1_end got %0b want 0", bus.stall_o); else n_pass++;
    step();
    set_in(8'hCE, 5'd2, 5'd9, 5'd11, 1'b0, 1'b0);  // add uses r9 via rt
    #1;
    n_total++; if (bus.stall_o !== 1'b1) $display("FAIL b2b_stall2 got %0b want 1", bus.stall_o); else n_pass++;
    n_total++; if (bus.ex_wreg_o !== 5'd9) $display("FAIL b2b_ex_wreg got %0d want 9", bus.ex_wreg_o); else n_pass++;
    step();
    n_total++; if (bus.ex_wreg_o !== 5'd0) $display("FAIL b2b_bubble got %0d want 0", bus.ex_wreg_o); else n_pass++;
    step();
    n_total++; if (bus.ex_wreg_o !== 5'd11) $display("FAIL b2b_reissue got %0d want 11", bus.ex_wreg_o); else n_pass++;
    idle();
  endtask

  task automatic test_jump_stall();
    do_reset();
    set_in(8'h53, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    step();
    set_in(8'h00, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0);   // jump reading r8
    #1;
    n_total++; if ({bus.stall_o, bus.ifid_flush_o} !== 2'b10) $display("FAIL js_first got %b want 10", {bus.stall_o, bus.ifid_flush_o}); else n_pass++;
    step();
    n_total++; if ({bus.stall_o, bus.ifid_flush_o} !== 2'b01) $display("FAIL js_second got %b want 01", {bus.stall_o, bus.ifid_flush_o}); else n_pass++;
    step();
    idle();
    // The jump advanced with its own word, not a bubble
    n_total++; if (bus.ex_aluop_o !== 2'b00) $display("FAIL js_no_bubble got %0h want 0", bus.ex_aluop_o); else n_pass++;
    set_in(8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    #1;
    n_total++; if (bus.ifid_flush_o !== 1'b1) $display("FAIL br_flush got %0b want 1", bus.ifid_flush_o); else n_pass++;
    idle();
    #1;
    n_total++; if (bus.ifid_flush_o !== 1'b0) $display("FAIL idle_flush got %0b want 0", bus.ifid_flush_o); else n_pass++;
  endtask

  task automatic test_zero_dest();
    do_reset();
`ifdef PERF_CNT_EN
    n_total++; if (stall_cnt !== 32'd0) $display("FAIL cnt_rst got %0d want 0", stall_cnt); else n_pass++;
`endif
    set_in(8'hC1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);   // addi rt=0
    step();
    idle();
    n_total++; if (bus.ex_wreg_o !== 5'd0) $display("FAIL z_ex_wreg got %0d want 0", bus.ex_wreg_o); else n_pass++;
    step();
    step();
    n_total++; if (bus.wb_regwrite_o !== 1'b0) $display("FAIL z_wb_regwrite got %0b want 0", bus.wb_regwrite_o); else n_pass++;
    n_total++; if (bus.wb_memtoreg_o !== 1'b1) $display("FAIL z_wb_memtoreg got %0b want 1", bus.wb_memtoreg_o); else n_pass++;
`ifdef PERF_CNT_EN
    set_in(8'h53, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    step();
    set_in(8'hCE, 5'd8, 5'd2, 5'd10, 1'b0, 1'b0);
    step();
    n_total++; if (stall_cnt !== 32'd1) $display("FAIL cnt_stall got %0d want 1", stall_cnt); else n_pass++;
    idle();
`endif
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_hazard();
    test_back_to_back();
    test_jump_stall();
    test_zero_dest();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
